// File: rtl/amba_pkg.sv
// Shared AHB-Lite types and constants for the decoder / response mux slice.
package amba_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // Four 256 MB regions at the bottom of the map; slave 0 sits in the LSB field.
  localparam logic [127:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                           32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_SLV_MASK = {4{32'hF000_0000}};

endpackage

// File: rtl/amba_default_slv.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// AHB ERROR response and keeps a saturating count of those errors.
module amba_default_slv
  import amba_pkg::*;
#(
  parameter int ECNT_W = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              unmapped,
  output logic              hreadyout,
  output logic              hresp,
  output logic [ECNT_W-1:0] err_cnt
);

  ds_state_t state;
  ds_state_t state_nxt;
  logic      err_start;

  // An unmapped active transfer is only taken when the bus actually accepts it.
  assign err_start = hready & unmapped & ((htrans == NONSEQ) | (htrans == SEQ));

  // State register.
  always_ff @(posedge hclk) begin
    if (!hresetn) state <= DS_IDLE;
    else          state <= state_nxt;
  end

  // Next state: ERR1 always advances, ERR2 may chain straight into another error.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DS_IDLE: state_nxt = err_start ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = err_start ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Response outputs: one wait cycle with ERROR, then ready with ERROR.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state)
      DS_IDLE: begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
      end
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      DS_ERR2: begin
        hreadyout = 1'b1;
        hresp     = HRESP_ERROR;
      end
      default: begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
      end
    endcase
  end

  // Count every entry into ERR1, holding at all-ones instead of wrapping.
  always_ff @(posedge hclk) begin
    if (!hresetn)                                 err_cnt <= '0;
    else if (state_nxt == DS_ERR1 && err_cnt != '1) err_cnt <= err_cnt + ECNT_W'(1);
  end

endmodule

// File: rtl/amba_deco_rmux.sv
// AHB-Lite address decoder with data-phase response multiplexer and an
// integrated default slave for unmapped addresses.
module amba_deco_rmux
  import amba_pkg::*;
#(
  parameter int                     AWIDTH   = 32,
  parameter int                     DWIDTH   = 32,
  parameter int                     NSLV     = 4,
  parameter logic [NSLV*AWIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*AWIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                     ECNT_W   = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [AWIDTH-1:0]      haddr,
  input  logic [1:0]             htrans,
  output logic [NSLV-1:0]        hsel,
  input  logic [NSLV*DWIDTH-1:0] hrdata_s,
  input  logic [NSLV-1:0]        hreadyout_s,
  input  logic [NSLV-1:0]        hresp_s,
  output logic [DWIDTH-1:0]      hrdata,
  output logic                   hready,
  output logic                   hresp,
  output logic [ECNT_W-1:0]      err_cnt
);

  // Index NSLV is reserved for the default slave, so dsel needs one extra code.
  localparam int            SW      = $clog2(NSLV + 1);
  localparam logic [SW-1:0] DEF_IDX = SW'(NSLV);

  logic [SW-1:0] dec_idx;
  logic [SW-1:0] dsel;
  logic          dec_hit;
  logic          unmapped;
  logic          ds_hreadyout;
  logic          ds_hresp;

  // Address decode with lowest-index priority, so overlapping regions never
  // produce more than one select.
  always_comb begin
    hsel    = '0;
    dec_idx = DEF_IDX;
    dec_hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!dec_hit &&
          ((haddr & SLV_MASK[i*AWIDTH +: AWIDTH]) == SLV_BASE[i*AWIDTH +: AWIDTH])) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
        hsel[i] = 1'b1;
      end
    end
  end

  assign unmapped = ~dec_hit;

  // Data-phase owner: follows the decode on accepted cycles, frozen during waits.
  always_ff @(posedge hclk) begin
    if (!hresetn)    dsel <= DEF_IDX;
    else if (hready) dsel <= dec_idx;
  end

  // Route the data-phase owner's response back to the master.
  always_comb begin
    hrdata = '0;
    hready = ds_hreadyout;
    hresp  = ds_hresp;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel == SW'(i)) begin
        hrdata = hrdata_s[i*DWIDTH +: DWIDTH];
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
      end
    end
  end

  amba_default_slv #(
    .ECNT_W(ECNT_W)
  ) u_default_slv (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hready   (hready),
    .htrans   (htrans),
    .unmapped (unmapped),
    .hreadyout(ds_hreadyout),
    .hresp    (ds_hresp),
    .err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_amba_deco_rmux.sv
// Bench for amba_deco_rmux: decode vector table, response scoreboard and
// hand-written wait-state / error / reset / saturation sequences.
module tb_amba_deco_rmux;
  import amba_pkg::*;

  localparam int NSLV = 4;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [3:0]   hsel, hsel2;
  logic [127:0] hrdata_s;
  logic [3:0]   hreadyout_s;
  logic [3:0]   hresp_s;
  logic [31:0]  hrdata, hrdata2;
  logic         hready, hready2;
  logic         hresp, hresp2;
  logic [15:0]  err_cnt;
  logic [1:0]   err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  amba_deco_rmux dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel(hsel), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .err_cnt(err_cnt)
  );

  // Narrow error counter instance to reach saturation quickly.
  amba_deco_rmux #(.ECNT_W(2)) dut_sat (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel(hsel2), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .hrdata(hrdata2), .hready(hready2), .hresp(hresp2),
    .err_cnt(err_cnt2)
  );

  function automatic logic [31:0] slaveData(input int i);
    return 32'hCAFE_0000 + 32'(i);
  endfunction

  // Reference decode of the default map: top nibble 0..3 selects that slave.
  function automatic int modelDecode(input logic [31:0] a);
    int n;
    n = int'(a[31:28]);
    return (n < NSLV) ? n : NSLV;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBus(input string name, input logic exp_ready, input logic exp_resp);
    checkOutput({name, "_hready"}, 32'(hready), 32'(exp_ready));
    checkOutput({name, "_hresp"}, 32'(hresp), 32'(exp_resp));
    checkOutput({name, "_hready_sat"}, 32'(hready2), 32'(exp_ready));
    checkOutput({name, "_hresp_sat"}, 32'(hresp2), 32'(exp_resp));
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] t);
    haddr  = a;
    htrans = t;
  endtask

  task automatic stepCycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge hclk);
  endtask

  task automatic doReset();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  // Scoreboard: every accepted NONSEQ/SEQ pushes its target; the entry is
  // popped and checked on the cycle its data phase completes.
  typedef struct {
    int          idx;
    logic [31:0] addr;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  sb_e;
  bit   dp_active = 1'b0;
  int   err_model = 0;
  int   err_model2 = 0;
  logic [31:0] exp_d;
  logic        exp_r;

  always @(negedge hclk) begin
    if (hresetn !== 1'b1) begin
      sb_q.delete();
      dp_active  = 1'b0;
      err_model  = 0;
      err_model2 = 0;
    end else begin
      checkOutput("err_cnt", 32'(err_cnt), 32'(err_model));
      checkOutput("err_cnt_sat", 32'(err_cnt2), 32'(err_model2));
      if (hready === 1'b1) begin
        if (dp_active) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_empty: data phase completed with no expected entry");
          end else begin
            sb_e = sb_q.pop_front();
            if (sb_e.idx == NSLV) begin
              exp_d = 32'h0;
              exp_r = 1'b1;
            end else begin
              exp_d = slaveData(sb_e.idx);
              exp_r = hresp_s[sb_e.idx];
            end
            checkOutput($sformatf("sb_hrdata@%08h", sb_e.addr), hrdata, exp_d);
            checkOutput($sformatf("sb_hresp@%08h", sb_e.addr), 32'(hresp), 32'(exp_r));
            checkOutput($sformatf("sb_hrdata_sat@%08h", sb_e.addr), hrdata2, exp_d);
            checkOutput($sformatf("sb_hresp_sat@%08h", sb_e.addr), 32'(hresp2), 32'(exp_r));
          end
        end
        if (htrans[1]) begin
          sb_e.idx  = modelDecode(haddr);
          sb_e.addr = haddr;
          sb_q.push_back(sb_e);
          dp_active = 1'b1;
          if (sb_e.idx == NSLV) begin
            if (err_model < 65535) err_model++;
            if (err_model2 < 3) err_model2++;
          end
        end else begin
          dp_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  exp_hsel;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0000, NONSEQ, 4'b0001};
    vecs[1] = '{32'h0FFF_FFFC, SEQ,    4'b0001};
    vecs[2] = '{32'h1000_0004, NONSEQ, 4'b0010};
    vecs[3] = '{32'h1FFF_FFFF, SEQ,    4'b0010};
    vecs[4] = '{32'h2000_0010, NONSEQ, 4'b0100};
    vecs[5] = '{32'h2000_0000, IDLE,   4'b0100};
    vecs[6] = '{32'h3FFF_FFFC, NONSEQ, 4'b1000};
    vecs[7] = '{32'h4000_0000, IDLE,   4'b0000};
    vecs[8] = '{32'hFFFF_FFFF, BUSY,   4'b0000};
    vecs[9] = '{32'hFFFF_FFFF, NONSEQ, 4'b0000};

    hresetn     = 1'b0;
    hreadyout_s = 4'hF;
    hresp_s     = 4'h0;
    for (int i = 0; i < NSLV; i++) hrdata_s[i*32 +: 32] = slaveData(i);
    applyStimulus(32'h4000_0000, IDLE);

    $display("[TB] reset");
    doReset();
    settle();
    checkOutput("rst_hsel", 32'(hsel), 32'h0);
    checkBus("rst", 1'b1, 1'b0);
    checkOutput("rst_hrdata", hrdata, 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    stepCycle();

    $display("[TB] mapped read");
    applyStimulus(32'h2000_0010, NONSEQ);
    settle();
    checkOutput("rd_hsel", 32'(hsel), 32'h4);
    stepCycle();
    applyStimulus(32'h4000_0000, IDLE);
    settle();
    checkOutput("rd_hrdata", hrdata, 32'hCAFE_0002);
    checkBus("rd", 1'b1, 1'b0);
    stepCycle();

    $display("[TB] wait states");
    applyStimulus(32'h1000_0000, NONSEQ);
    stepCycle();
    applyStimulus(32'h3000_0000, NONSEQ);
    hreadyout_s[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkBus($sformatf("ws%0d", i), 1'b0, 1'b0);
      checkOutput($sformatf("ws%0d_hrdata", i), hrdata, 32'hCAFE_0001);
      stepCycle();
    end
    hreadyout_s[1] = 1'b1;
    settle();
    checkBus("ws_done", 1'b1, 1'b0);
    checkOutput("ws_done_hrdata", hrdata, 32'hCAFE_0001);
    stepCycle();
    applyStimulus(32'h4000_0000, IDLE);
    settle();
    checkOutput("ws_next_hrdata", hrdata, 32'hCAFE_0003);
    stepCycle();

    $display("[TB] slave error pass-through");
    applyStimulus(32'h0000_0000, NONSEQ);
    stepCycle();
    hresp_s[0] = 1'b1;
    applyStimulus(32'h4000_0000, IDLE);
    settle();
    checkOutput("slv_err_hresp", 32'(hresp), 32'h1);
    stepCycle();
    hresp_s[0] = 1'b0;

    $display("[TB] decode table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].trans);
      settle();
      checkOutput($sformatf("vec%0d_hsel", i), 32'(hsel), 32'(vecs[i].exp_hsel));
      checkOutput($sformatf("vec%0d_hsel_sat", i), 32'(hsel2), 32'(vecs[i].exp_hsel));
      stepCycle();
    end
    applyStimulus(32'h4000_0000, IDLE);
    repeat (3) stepCycle();

    $display("[TB] unmapped error");
    doReset();
    applyStimulus(32'h8000_0000, NONSEQ);
    settle();
    checkOutput("ue_hsel", 32'(hsel), 32'h0);
    stepCycle();
    applyStimulus(32'h8000_0000, IDLE);
    settle();
    checkBus("ue_err1", 1'b0, 1'b1);
    stepCycle();
    settle();
    checkBus("ue_err2", 1'b1, 1'b1);
    checkOutput("ue_err_cnt", 32'(err_cnt), 32'h1);
    stepCycle();
    settle();
    checkBus("ue_idle", 1'b1, 1'b0);
    checkOutput("ue_idle_err_cnt", 32'(err_cnt), 32'h1);
    stepCycle();

    $display("[TB] back-to-back errors");
    doReset();
    applyStimulus(32'h8000_0000, NONSEQ);
    stepCycle();
    applyStimulus(32'h8000_0004, SEQ);
    settle();
    checkBus("bb_err1a", 1'b0, 1'b1);
    stepCycle();
    settle();
    checkBus("bb_err2a", 1'b1, 1'b1);
    stepCycle();
    applyStimulus(32'h4000_0000, IDLE);
    settle();
    checkBus("bb_err1b", 1'b0, 1'b1);
    stepCycle();
    settle();
    checkBus("bb_err2b", 1'b1, 1'b1);
    checkOutput("bb_err_cnt", 32'(err_cnt), 32'h2);
    stepCycle();
    applyStimulus(32'h9000_0000, NONSEQ);
    stepCycle();
    applyStimulus(32'h0000_0040, NONSEQ);
    settle();
    checkBus("bbm_err1", 1'b0, 1'b1);
    stepCycle();
    settle();
    checkBus("bbm_err2", 1'b1, 1'b1);
    checkOutput("bbm_hsel", 32'(hsel), 32'h1);
    stepCycle();
    applyStimulus(32'h4000_0000, IDLE);
    settle();
    checkBus("bbm_mapped", 1'b1, 1'b0);
    checkOutput("bbm_hrdata", hrdata, 32'hCAFE_0000);
    checkOutput("bbm_err_cnt", 32'(err_cnt), 32'h3);
    stepCycle();

    $display("[TB] reset mid-error");
    applyStimulus(32'hA000_0000, NONSEQ);
    stepCycle();
    applyStimulus(32'h4000_0000, IDLE);
    hresetn = 1'b0;
    settle();
    checkBus("rme_err1", 1'b0, 1'b1);
    stepCycle();
    hresetn = 1'b1;
    settle();
    checkBus("rme_after", 1'b1, 1'b0);
    checkOutput("rme_err_cnt", 32'(err_cnt), 32'h0);
    stepCycle();

    $display("[TB] error counter saturation");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'hC000_0000 + 32'(i), NONSEQ);
      stepCycle();
      applyStimulus(32'h4000_0000, IDLE);
      repeat (2) stepCycle();
    end
    settle();
    checkOutput("sat_err_cnt_wide", 32'(err_cnt), 32'h5);
    checkOutput("sat_err_cnt_narrow", 32'(err_cnt2), 32'h3);
    stepCycle();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
